// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the tick-driven delay timer.
package tick_timer_pkg;
    typedef enum logic {IDLE, RUN} state_t;

    localparam int CNT_W_DEF = 8;
    localparam int ZERO_CNT  = 0;
endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter that saturates at zero; clr wins over load, load over dec.
module tick_down_counter
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] remaining,
    output logic             is_one
);
    localparam logic [CNT_W-1:0] ZERO = CNT_W'(ZERO_CNT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            remaining <= ZERO;
        else if (clr)
            remaining <= ZERO;
        else if (load)
            remaining <= load_val;
        else if (dec && remaining != ZERO)
            remaining <= remaining - ONE;
    end

    assign is_one = (remaining == ONE);
endmodule

// File: rtl/tick_delay_timer.sv
// Programmable wait measured in tick pulses; one-cycle done on completion.
// Optional freeze input enabled by defining TICK_DELAY_TIMER_PAUSE_EN.
module tick_delay_timer
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [CNT_W-1:0] duration,
    input  logic             abort,
`ifdef TICK_DELAY_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);
    state_t state;
    logic   count_en, load, clr, is_one, complete, dur_zero;

`ifdef TICK_DELAY_TIMER_PAUSE_EN
    assign count_en = (state == RUN) && tick && !pause;
`else
    assign count_en = (state == RUN) && tick;
`endif

    assign dur_zero = (duration == CNT_W'(ZERO_CNT));
    assign load     = (state == IDLE) && start && !dur_zero;
    assign clr      = (state == RUN) && abort;
    // abort beats a coincident final tick, so no done in that case
    assign complete = count_en && is_one && !abort;

    tick_down_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (duration),
        .dec      (count_en),
        .clr      (clr),
        .remaining(remaining),
        .is_one   (is_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dur_zero) begin
                            done <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (complete) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/tick_delay_timer.md
# tick_delay_timer

Consumer side of the periodic tick interface. It accepts a start request carrying a duration expressed in ticks and counts incoming one-cycle `tick` pulses from the system tick generator. When the requested number of ticks has elapsed, it issues a one-cycle `done` pulse. It sits between the tick generators and the control FSMs, which use it for programmable waits without owning their own counters.

## Interface
- `CNT_W`, 8: width of `duration` and `remaining`; maximum wait is 2^CNT_W−1 ticks.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `tick`  in  1  one-cycle pulse from the tick generator, synchronous to `clk`.
- `start`  in  1  request a new wait; sampled only in IDLE.
- `duration`  in  CNT_W  wait length in ticks; sampled with `start`.
- `abort`  in  1  cancel a running wait.
- `pause`  in  1  freeze counting. Present only with `TICK_DELAY_TIMER_PAUSE_EN`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the wait completes.
- `remaining`  out  CNT_W  ticks left in the current wait; 0 in IDLE.

## Operation
- FSM has two states, IDLE and RUN. All outputs are registered.
- **IDLE, `start`=1, `duration`≠0:** load `remaining`=`duration` and go to RUN. `busy`=1 from the next cycle.
- **IDLE, `start`=1, `duration`=0:** stay in IDLE and pulse `done` on the next cycle. `busy` stays 0.
- **RUN, each cycle with `tick`=1:** `remaining` decrements by 1.
- **Completion:** when `remaining`=1 and `tick`=1:
  - `remaining`←0 and state←IDLE;
  - `done`←1 for exactly one cycle, and `busy`←0 in the same cycle.
- **`abort` in RUN:** state←IDLE, `remaining`←0, `busy`←0. No `done` is issued.
- **`abort` priority:** `abort` beats a coincident completing tick, so there is no `done` in that case.
- **`abort` in IDLE:** ignored.
- **`start` in RUN:** ignored. No restart, no queueing.
- **`tick` in the same cycle as an accepted `start`:** not counted. Counting begins with the first tick strictly after the load cycle.
- **`start` in the cycle `done` is high:** accepted, because the state is already IDLE. This gives back-to-back waits.
- **Arithmetic:** unsigned, CNT_W bits. `remaining` never decrements below 0 and never wraps.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `remaining`=0.
- **Async reset:** asserting `reset` mid-RUN immediately clears everything. No `done` is issued.
- **Load latency:** `start` sampled at edge k gives `busy`=1 and `remaining`=`duration` after edge k.
- **Completion latency:**
  - `done` is high in the cycle after the edge that samples the N-th counted tick.
  - With a tick every P cycles and the first tick P cycles after the load, `done` rises N·P cycles after the load edge.
- **Duration = 0:** `done` is high in the cycle after the `start` edge.
- **`done` width:** exactly one `clk` cycle, never stretched.

## Configuration
- `TICK_DELAY_TIMER_PAUSE_EN` **defined:**
  - `pause` port exists;
  - in RUN with `pause`=1, ticks are ignored and `remaining` holds;
  - `abort` still works while paused;
  - `pause` has no effect in IDLE.
- **Undefined:** no `pause` port; every tick in RUN counts.

## Structure
- **Shared package `tick_timer_pkg`:**
  - state enum {IDLE, RUN};
  - default `CNT_W` constant;
  - a constant for the zero count.
- **Sub-module `tick_down_counter`:** natural split.
  - Inputs: `load`, `load_val`, `dec`, `clr`.
  - Output: `remaining`, plus a combinational `is_one` flag used by the FSM.
  - Saturating at 0.
- **FSM and `done`/`busy` registers** stay in `tick_delay_timer`.

## Test plan
- **Basic wait:** `duration`=3, tick every 2 cycles starting 2 cycles after the load -> `remaining` goes 3,2,1,0; `done` is a single pulse 6 cycles after the load edge; `busy` is high for exactly those 6 cycles.
- **Zero duration:** `start`, `duration`=0 -> `done` for 1 cycle on the next cycle, `busy` never 1, `remaining`=0.
- **Abort vs. completion:** `duration`=2, assert `abort` in the same cycle as the 2nd tick -> no `done`, `busy`=0, `remaining`=0 next cycle.
- **Ignored inputs:** `start` with `duration`=5 while running `duration`=4, plus a tick coincident with the original `start` -> the wait ends after 4 counted ticks, and the extra tick is not counted.
- **Reset and back-to-back:**
  - `reset` pulsed mid-RUN with `remaining`=7 -> immediate IDLE, all outputs 0, no `done`;
  - then `start` asserted in the `done` cycle of a previous wait -> the new wait loads correctly.
- **With `TICK_DELAY_TIMER_PAUSE_EN`:** `duration`=3, `pause`=1 across 2 ticks after the 1st tick -> `remaining` holds at 2; `done` occurs only after 2 further unpaused ticks.
